// File: rtl/reaction_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_ctrl
// Reaction-time game controller. It starts the start-lights sequencer, waits
// for the full light pattern followed by lights-out, and then counts timebase
// ticks until the player presses the button. A press before lights-out is
// reported as a false start. If there is no press within TIMEOUT ticks, the
// attempt is reported as timed out. The result is held until the consumer
// acknowledges it.
//
// Parameters
//   CW       reaction counter / result width
//   TIMEOUT  tick count at which an attempt is abandoned (must be < 2**CW)
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous reset, active low
//   go            in   start request (sampled in IDLE only)
//   lights        in   [7:0] lamp pattern from the sequencer, bit i = lamp i
//   tick          in   one-cycle timebase strobe
//   btn           in   player button level (already synchronous)
//   ack           in   result acknowledge (honoured in DONE only)
//   fsm_trigger   out  one-cycle start pulse to the sequencer (registered)
//   busy          out  high in every state except IDLE (state decode)
//   result_valid  out  result fields valid (state decode)
//   react_time    out  [CW-1:0] reaction time in ticks (registered)
//   false_start   out  button pressed before lights-out (registered)
//   timed_out     out  no press within TIMEOUT ticks (registered)
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for go; previous result still visible
// ARM    | start pulse to sequencer, result and counters cleared
// LIGHTS | lamps coming on; a press here is a false start
// TIMING | lamps out; counting ticks until press or timeout
// DONE   | result valid, held until ack
// ---------------------------------------------------------------------------
module reaction_ctrl #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [7:0]    lights,
  input  logic          tick,
  input  logic          btn,
  input  logic          ack,
  output logic          fsm_trigger,
  output logic          busy,
  output logic          result_valid,
  output logic [CW-1:0] react_time,
  output logic          false_start,
  output logic          timed_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LIGHTS = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_t        state;
  state_t        state_nx;

  logic          btn_q;
  logic          press;
  logic          lit;
  logic          lit_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          trig_nx;
  logic [CW-1:0] rt_nx;
  logic          fs_nx;
  logic          to_nx;

  // Rising edge of the button. A button already held when LIGHTS is entered
  // has btn_q=1 and so never counts as a press until it is released first.
  assign press = btn & ~btn_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (go) state_nx = S_ARM;
      end
      S_ARM: begin
        state_nx = S_LIGHTS;
      end
      S_LIGHTS: begin
        // A press outranks lights-out in the same cycle.
        if (press)                           state_nx = S_DONE;
        else if (lit && (lights == 8'h00))   state_nx = S_TIMING;
      end
      S_TIMING: begin
        if (press || (count == TIMEOUT_C))   state_nx = S_DONE;
      end
      S_DONE: begin
        if (ack) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output / datapath logic. busy and result_valid come straight from the
  // state register; everything else is computed here and registered below.
  always_comb begin
    busy         = (state != S_IDLE);
    result_valid = (state == S_DONE);
    trig_nx      = 1'b0;
    lit_nx       = lit;
    count_nx     = count;
    rt_nx        = react_time;
    fs_nx        = false_start;
    to_nx        = timed_out;
    case (state)
      S_IDLE: begin
        // Clearing on the way into ARM makes the pulse and the cleared
        // result visible during the ARM cycle itself.
        if (go) begin
          trig_nx  = 1'b1;
          lit_nx   = 1'b0;
          count_nx = '0;
          rt_nx    = '0;
          fs_nx    = 1'b0;
          to_nx    = 1'b0;
        end
      end
      S_LIGHTS: begin
        if (press) begin
          fs_nx = 1'b1;
          rt_nx = '0;
        end else begin
          if (lights == 8'hFF) lit_nx = 1'b1;
          if (lit && (lights == 8'h00)) count_nx = '0;
        end
      end
      S_TIMING: begin
        // Leaving at count==TIMEOUT keeps the count saturated: it can
        // never be incremented past TIMEOUT.
        if (press) begin
          rt_nx = count;
        end else if (count == TIMEOUT_C) begin
          to_nx = 1'b1;
          rt_nx = TIMEOUT_C;
        end else if (tick) begin
          count_nx = count + ONE_C;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and internal datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q       <= 1'b0;
      lit         <= 1'b0;
      count       <= '0;
      fsm_trigger <= 1'b0;
      react_time  <= '0;
      false_start <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      btn_q       <= btn;
      lit         <= lit_nx;
      count       <= count_nx;
      fsm_trigger <= trig_nx;
      react_time  <= rt_nx;
      false_start <= fs_nx;
      timed_out   <= to_nx;
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl. Two instances share clk, rst, lights,
// tick and btn: dut runs with the default TIMEOUT, dut5 with TIMEOUT=5.
// Each instance has its own go/ack, so the idle instance ignores the
// other's traffic.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, go5, ack, ack5, tick, btn;
  logic [7:0]  lights;

  logic        trig, busy, rv, fs, to;
  logic [15:0] rt;
  logic        trig5, busy5, rv5, fs5, to5;
  logic [15:0] rt5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reaction_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .lights(lights), .tick(tick), .btn(btn),
    .ack(ack), .fsm_trigger(trig), .busy(busy), .result_valid(rv),
    .react_time(rt), .false_start(fs), .timed_out(to)
  );

  reaction_ctrl #(.CW(16), .TIMEOUT(5)) dut5 (
    .clk(clk), .rst(rst), .go(go5), .lights(lights), .tick(tick), .btn(btn),
    .ack(ack5), .fsm_trigger(trig5), .busy(busy5), .result_valid(rv5),
    .react_time(rt5), .false_start(fs5), .timed_out(to5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are taken at this edge; outputs
  // are then looked at 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Lamps 01,03,...,FF, one value per cycle.
  task automatic ramp();
    for (int i = 0; i < 8; i++) begin
      lights = 8'((1 << (i + 1)) - 1);
      cyc();
    end
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  initial begin
    rst = 1'b0; go = 0; go5 = 0; ack = 0; ack5 = 0; tick = 0; btn = 0; lights = 8'h00;

    // ---- reset values
    #22;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv",   32'(rv),   0);
    chk("rst_rt",   32'(rt),   0);
    chk("rst_fs",   32'(fs),   0);
    chk("rst_to",   32'(to),   0);
    rst = 1'b1;
    cyc();
    chk("idle_busy", 32'(busy), 0);

    // ---- normal run: 37 ticks then press
    go = 1; cyc();
    chk("arm_trig", 32'(trig), 1);
    chk("arm_busy", 32'(busy), 1);
    go = 0;
    ramp();
    chk("trig_once", 32'(trig), 0);
    lights = 8'h00; cyc();
    chk("timing_rv", 32'(rv), 0);
    tick_pulses(37);
    btn = 1; cyc();
    chk("norm_rv", 32'(rv), 1);
    chk("norm_rt", 32'(rt), 37);
    chk("norm_fs", 32'(fs), 0);
    chk("norm_to", 32'(to), 0);

    // ---- handshake: ack withheld 10 cycles, go and btn wiggling
    for (int i = 0; i < 10; i++) begin
      go = i[0]; btn = ~i[0]; tick = i[1];
      cyc();
      chk("hold_rv", 32'(rv), 1);
      chk("hold_rt", 32'(rt), 37);
      chk("hold_fs", 32'(fs), 0);
      chk("hold_to", 32'(to), 0);
    end
    go = 0; btn = 0; tick = 0; ack = 1; cyc();
    chk("ack_rv",   32'(rv),   0);
    chk("ack_busy", 32'(busy), 0);
    chk("idle_rt",  32'(rt),   37);
    ack = 0; cyc();
    chk("idle2_busy", 32'(busy), 0);
    chk("idle2_rt",   32'(rt),   37);

    // ---- false start at lights=0F
    go = 1; cyc();
    chk("arm_clr_rt", 32'(rt), 0);
    go = 0;
    lights = 8'h01; cyc();
    lights = 8'h03; cyc();
    lights = 8'h07; cyc();
    lights = 8'h0F; cyc();
    btn = 1; cyc();
    chk("fs_rv", 32'(rv), 1);
    chk("fs_fs", 32'(fs), 1);
    chk("fs_rt", 32'(rt), 0);
    chk("fs_to", 32'(to), 0);
    ack = 1; cyc();
    chk("fs_ack_busy", 32'(busy), 0);
    chk("fs_hold",     32'(fs),   1);
    ack = 0; btn = 0; lights = 8'h00; cyc();

    // ---- btn held from before ARM, early lights=00 ignored, ticks in
    //      LIGHTS ignored, then press together with tick at count=3
    btn = 1; cyc();
    go = 1; cyc();
    go = 0; tick = 1; lights = 8'h00; cyc();
    lights = 8'h00; cyc();
    ramp();
    lights = 8'h00; cyc();
    tick = 0;
    chk("held_rv", 32'(rv), 0);
    chk("held_fs", 32'(fs), 0);
    btn = 0;
    tick_pulses(3);
    btn = 1; tick = 1; cyc();
    tick = 0;
    chk("b3_rv", 32'(rv), 1);
    chk("b3_rt", 32'(rt), 3);
    chk("b3_fs", 32'(fs), 0);
    chk("b3_to", 32'(to), 0);
    btn = 0; ack = 1; cyc();
    ack = 0; cyc();

    // ---- timeout on TIMEOUT=5 instance
    go5 = 1; cyc();
    go5 = 0;
    ramp();
    lights = 8'h00; cyc();
    chk("to_main_idle", 32'(busy), 0);
    tick = 1; cyc(); tick = 0; cyc();
    tick = 1; cyc(); tick = 0; cyc();
    tick = 1; cyc(); tick = 0; cyc();
    tick = 1; cyc(); tick = 0; cyc();
    tick = 1; cyc();
    chk("to_pre_rv", 32'(rv5), 0);
    tick = 0; cyc();
    chk("to_rv", 32'(rv5), 1);
    chk("to_to", 32'(to5), 1);
    chk("to_rt", 32'(rt5), 5);
    chk("to_fs", 32'(fs5), 0);
    tick_pulses(3);
    chk("to_sat_rt", 32'(rt5), 5);
    ack5 = 1; cyc();
    ack5 = 0;
    chk("to_ack_busy", 32'(busy5), 0);

    // ---- press exactly at count==TIMEOUT wins over timeout
    go5 = 1; cyc();
    go5 = 0;
    ramp();
    lights = 8'h00; cyc();
    tick_pulses(4);
    tick = 1; cyc();
    tick = 0; btn = 1; cyc();
    chk("pt_rv", 32'(rv5), 1);
    chk("pt_to", 32'(to5), 0);
    chk("pt_rt", 32'(rt5), 5);
    chk("pt_fs", 32'(fs5), 0);
    chk("pt_main_idle", 32'(busy), 0);
    btn = 0; ack5 = 1; cyc();
    ack5 = 0; cyc();

    // ---- asynchronous reset mid-TIMING, then a fresh run
    go = 1; cyc();
    go = 0;
    ramp();
    lights = 8'h00; cyc();
    tick_pulses(2);
    chk("pre_rst_busy", 32'(busy), 1);
    #2; rst = 1'b0; #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rv",   32'(rv),   0);
    chk("arst_rt",   32'(rt),   0);
    chk("arst_fs",   32'(fs),   0);
    chk("arst_to",   32'(to),   0);
    #3; rst = 1'b1;
    cyc();
    chk("post_rst_busy", 32'(busy), 0);
    go = 1; cyc();
    chk("post_trig", 32'(trig), 1);
    go = 0;
    ramp();
    lights = 8'h00; cyc();
    tick_pulses(2);
    btn = 1; cyc();
    chk("post_rv", 32'(rv), 1);
    chk("post_rt", 32'(rt), 2);
    chk("post_fs", 32'(fs), 0);
    chk("post_to", 32'(to), 0);
    btn = 0; ack = 1; cyc();
    ack = 0;
    chk("post_ack_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter CW, default 16: reaction counter and result width.
REQ-002 Parameter TIMEOUT, default 2000: tick count at which an attempt is abandoned; must be less than 2^CW.
REQ-003 clk  in  1: single clock; all state changes on the rising edge.
REQ-004 rst  in  1: asynchronous, active-low reset.
REQ-005 go  in  1: start request, sampled only in IDLE.
REQ-006 lights  in  8: light pattern from the start-lights sequencer; bit i = lamp i.
REQ-007 tick  in  1: timebase strobe, one cycle wide, from a clktick instance.
REQ-008 btn  in  1: player button, synchronous level.
REQ-009 ack  in  1: consumer acknowledge for the result.
REQ-010 fsm_trigger  out  1: one-cycle start pulse to the sequencer.
REQ-011 busy  out  1: high in every state except IDLE.
REQ-012 result_valid  out  1: result fields are valid.
REQ-013 react_time  out  CW: reaction time in ticks.
REQ-014 false_start  out  1: button pressed before lights out.
REQ-015 timed_out  out  1: no press within TIMEOUT ticks.

Function
REQ-016 States: IDLE, ARM, LIGHTS, TIMING, DONE; encoding is free, and unreachable codes shall return to IDLE.
REQ-017 btn edge detection: btn_q is registered every cycle; press = btn & ~btn_q. A button already held entering LIGHTS is not a press.
REQ-018 IDLE: go=1 -> ARM; otherwise remain.
REQ-019 ARM: fsm_trigger=1 for exactly this one cycle; clear lit flag, count, react_time, false_start and timed_out; -> LIGHTS unconditionally.
REQ-020 LIGHTS, lit flag: set when lights==8'hFF.
REQ-021 LIGHTS, lights out: when lit=1 and lights==8'h00 -> TIMING with count=0; lights==0 before lit is set is ignored.
REQ-022 LIGHTS, false start: a press -> DONE with false_start=1, react_time=0; this takes priority over lights-out in the same cycle.
REQ-023 TIMING, counting: count increments by 1 on each cycle where tick=1 and there is no press.
REQ-024 TIMING, press: -> DONE with react_time=count as held at the start of that cycle; a tick in the same cycle is not counted.
REQ-025 TIMING, timeout: count==TIMEOUT with no press -> DONE with timed_out=1, react_time=TIMEOUT. A press in the same cycle wins: timed_out=0, react_time=TIMEOUT.
REQ-026 Count saturation: count never exceeds TIMEOUT; no wrap-around.
REQ-027 DONE: result_valid=1; all result outputs stay stable until ack=1. With ack=1 -> IDLE, and result_valid=0 from the next cycle.
REQ-028 Result hold: react_time, false_start and timed_out keep their values in IDLE until the next ARM.
REQ-029 Ignored inputs: go outside IDLE, ack outside DONE, and presses in IDLE, ARM or DONE have no effect.
REQ-030 All outputs are registered, except busy and result_valid, which are decoded from the state register.

Reset
REQ-031 rst=0 forces IDLE immediately, regardless of clk.
REQ-032 Reset values: fsm_trigger=0, busy=0, result_valid=0, react_time=0, false_start=0, timed_out=0; count=0, lit=0, btn_q=0.
REQ-033 Reset mid-attempt, in any state, abandons the attempt; no result is produced.
REQ-034 Leaving reset: first state change occurs on the first rising clk edge after rst=1.

Verification
REQ-035 Normal run: go=1 one cycle; lights ramp 01..FF, then 00; 37 ticks; then btn rises -> fsm_trigger pulses one cycle, react_time=37, result_valid=1, false_start=0, timed_out=0.
REQ-036 False start: btn rises while lights=8'h0F -> DONE next cycle with false_start=1, react_time=0; an ack pulse gives busy=0 one cycle later.
REQ-037 Timeout: TIMEOUT=5, no btn -> after the 5th tick, timed_out=1, react_time=5; count does not pass 5.
REQ-038 Boundaries: btn rising together with tick at count=3 -> react_time=3. btn held high from ARM through lights-out with no further edge -> no false start. Press at count==TIMEOUT -> timed_out=0.
REQ-039 Handshake: ack withheld 10 cycles -> result_valid and all result outputs stable for all 10 cycles; go asserted during DONE is ignored.
REQ-040 Reset: rst=0 asserted mid-TIMING between clock edges -> all outputs equal REQ-032 values before the next edge; a new go afterwards runs normally.
